switch_debouncer: RTL
=====================

Name: switch_debouncer

Overview:
- Input conditioning stage directly upstream of the board-level priority encoder.
- Synchronises WIDTH raw slide-switch/button lines into i_clk and debounces each bit independently.
- Produces a clean level vector that drives the encoder's one-hot input, plus one-cycle rise/fall pulses per bit.
- Optionally keeps a sticky pending-request vector for event-style use.

Parameters:
- WIDTH, 8, number of independent input lines.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before accepting a new level (1 ms at 50 MHz); legal range ≥ 2.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.

Ports:
- i_clk  input  1  system clock (50 MHz on board).
- i_rst_n  input  1  asynchronous active-low reset.
- i_raw  input  WIDTH  raw asynchronous switch/button levels.
- i_clr  input  WIDTH  per-bit clear mask for o_pend; ignored when the feature is compiled out.
- o_dat  output  WIDTH  debounced level vector, feeds the encoder one-hot input.
- o_rise  output  WIDTH  one-cycle pulse per bit on an accepted 0→1 transition.
- o_fall  output  WIDTH  one-cycle pulse per bit on an accepted 1→0 transition.
- o_pend  output  WIDTH  sticky rise flags; tied to 0 without the feature.

Behaviour:
- Reset is asynchronous on i_rst_n low. All of the following clear to 0:
  - both synchroniser flops;
  - the stable register (o_dat);
  - all counters;
  - o_rise, o_fall and o_pend.
- Reset has priority over every other event, including mid-debounce; an in-flight count is discarded.
- Per bit, a two-flop synchroniser stage gives s = sync2.
- Per bit, each clock edge after reset:
  - If s == stable: cnt <= 0. No pulse.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0. o_rise <= s, o_fall <= ~s, both for exactly one cycle.
  - Else: cnt <= cnt+1.
- Latency: a clean raw change that is stable before edge k appears on o_dat at edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges counting the capture edge.
- o_rise/o_fall assert on the same edge that o_dat changes and deassert on the next edge.
- Bounce handling: any return of s to the stable value before the count completes resets cnt to 0. Pulses narrower than DEBOUNCE_CYCLES cycles are never propagated.
- A line held at 1 through reset release is debounced normally. It produces o_dat=1 and one o_rise pulse after DEBOUNCE_CYCLES+2 edges.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses.
- o_rise and o_fall are never both high on the same bit.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

Optional Feature:
- Macro: SW_DEBOUNCE_PENDING_EN.
- Defined:
  - o_pend[i] sets on o_rise[i].
  - o_pend[i] clears on i_clr[i] (registered, one edge).
  - Set and clear on the same edge leaves o_pend[i]=1 (set wins).
  - o_pend is unaffected by o_fall.
- Undefined: o_pend is constant 0, i_clr is unused, and no pending flops are generated.

Decomposition:
- Shared package holds:
  - CLK_FREQ_HZ = 50_000_000;
  - DEBOUNCE_MS = 1;
  - the derived DEBOUNCE_CYCLES default constant.
- Sub-module debounce_cell: single-bit synchroniser, counter, stable flop and pulse outputs (same i_clk/i_rst_n).
- Generated WIDTH times in switch_debouncer, which adds only the optional pending vector.

Test Plan:
All scenarios use WIDTH=8, DEBOUNCE_CYCLES=4.
- Reset: i_raw=8'h00, hold i_rst_n=0 → o_dat, o_rise, o_fall and o_pend = 0.
  - Assert i_rst_n low asynchronously mid-cycle with o_dat=8'h0F → all outputs 0 immediately.
- Clean rise: i_raw goes 8'h00→8'h04 before edge k → o_dat=8'h04 and o_rise=8'h04 at edge k+5.
  - o_rise returns to 0 at edge k+6; o_fall stays 0.
- Bounce rejection: bit0 toggles 1,0,1,0 on alternate cycles, then holds 0 → o_dat[0] stays 0; no pulses ever.
- Multi-bit fall: from o_dat=8'h81, i_raw→8'h00 → o_fall=8'h81 for one cycle at edge k+5; o_dat=8'h00.
- Held at reset: i_raw=8'h10 during reset, release → o_dat=8'h10 and o_rise=8'h10 at the 6th edge after release.
- Pending (SW_DEBOUNCE_PENDING_EN):
  - rise on bit3 → o_pend=8'h08;
  - i_clr=8'h08 on the same edge as a second bit3 rise → o_pend stays 8'h08;
  - i_clr=8'h08 alone → o_pend=8'h00 next edge.
  - Without the macro, o_pend is always 8'h00.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch debouncer: board clock and default debounce window.
// The default window is derived from the board clock so a clock change only touches this file.
package switch_debouncer_pkg;

   localparam int unsigned CLK_FREQ_HZ = 50_000_000;
   localparam int unsigned DEBOUNCE_MS = 1;

   // Converts a debounce time in milliseconds into board clock cycles
   function automatic int unsigned ms_to_cycles(input int unsigned ms);
      return (CLK_FREQ_HZ / 1000) * ms;
   endfunction

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = ms_to_cycles(DEBOUNCE_MS);

endpackage

// File: rtl/switch_debouncer_debounce_cell.sv
// Single-bit debounce cell: two-flop synchroniser, stability counter, accepted level and
// one-cycle rise/fall pulses. A new level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with the current accepted level.
module debounce_cell
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_dat,
   output logic o_rise,
   output logic o_fall,
   // Combinational: high during the cycle whose closing edge raises o_rise
   output logic o_rise_evt
);

   localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 stable_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 rise_q;
   logic                 fall_q;
   logic                 differs;
   logic                 accept;

   // Decide whether the synchronised level is accepted this edge and advance the counter
   always_comb begin
      differs = (sync2_q != stable_q);
      accept  = differs && (cnt_q == CNT_LAST);
      cnt_d   = '0;
      if (differs && !accept) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Two-flop synchroniser for the asynchronous raw line
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_raw;
         sync2_q <= sync1_q;
      end
   end

   // Counter, accepted level and edge pulses; pulses last exactly one cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rise_q <= accept & sync2_q;
         fall_q <= accept & ~sync2_q;
         if (accept) begin
            stable_q <= sync2_q;
         end
      end
   end

   assign o_dat      = stable_q;
   assign o_rise     = rise_q;
   assign o_fall     = fall_q;
   assign o_rise_evt = accept & sync2_q;

endmodule

// File: rtl/switch_debouncer.sv
// WIDTH-bit switch/button debouncer feeding the priority encoder. Each bit is conditioned by an
// independent debounce_cell. Define SW_DEBOUNCE_PENDING_EN to add a sticky pending-rise vector
// (o_pend) cleared per bit by i_clr; without it o_pend is tied low and i_clr is ignored.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_raw,
   input  logic [WIDTH-1:0] i_clr,
   output logic [WIDTH-1:0] o_dat,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic [WIDTH-1:0] o_pend
);

   logic [WIDTH-1:0] rise_evt;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_raw     (i_raw[gi]),
         .o_dat     (o_dat[gi]),
         .o_rise    (o_rise[gi]),
         .o_fall    (o_fall[gi]),
         .o_rise_evt(rise_evt[gi])
      );
   end

`ifdef SW_DEBOUNCE_PENDING_EN
   logic [WIDTH-1:0] pend_q;

   // Sticky pending flags: set on the edge o_rise asserts, set beats a same-edge clear
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~i_clr) | rise_evt;
      end
   end

   assign o_pend = pend_q;
`else
   logic unused_pend_inputs;
   assign unused_pend_inputs = ^{i_clr, rise_evt};
   assign o_pend = '0;
`endif

endmodule
